load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle initiator that turns CPU load/store requests into accesses on the word-wide data memory port. It sits between the datapath's memory stage and the data memory. It provides byte, halfword and word accesses with sign/zero extension on loads and read-modify-write merging on sub-word stores, because the memory only writes whole words. A valid/ready request channel and a valid/ready response channel decouple it from the core.

## Interface
- ADDR_W, 10, word-address width of the data memory (1024 words)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  load result, extended; 0 for stores
- resp_err  out  1  misaligned access (see Configuration)
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]; upper bits ignored (wrap)
- mem_we  out  1  word write strobe, sampled by memory at posedge clk
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data for the current mem_addr

## Operation
- FSM states: IDLE, RD, WR, DONE. All request fields are latched on acceptance (req_valid & req_ready).
- IDLE: req_ready=1. On acceptance:
  - misaligned with trap enabled -> DONE with err=1;
  - word store -> WR;
  - any load or sub-word store -> RD.
- RD: drive mem_addr; capture mem_rdata into a word register.
  - load -> DONE;
  - sub-word store -> WR.
- WR: mem_we=1 for exactly one cycle. mem_wdata is either req_wdata (word) or the captured word with the addressed lane(s) replaced. Next state DONE.
- DONE: resp_valid=1, with resp_rdata/resp_err held stable until resp_ready. Return to IDLE on the handshake.
- Byte lanes are little-endian: addr[1:0]=0 maps to bits 7:0, and halfword addr[1]=0 maps to bits 15:0.
- Load extraction: select the lane, then sign- or zero-extend to 32 bits. A word load ignores req_signed.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Byte accesses are never misaligned.
- req_valid is ignored outside IDLE. A new request can be accepted in the cycle after the DONE handshake, not in the same cycle.
- mem_we is never asserted for loads or for trapped accesses.

## Timing
- Reset (reset=0 at posedge):
  - state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - req_ready=1 from the first cycle after reset.
- Reset asserted in any state aborts the operation. A WR cycle coinciding with reset must not assert mem_we.
- Latency from acceptance edge to resp_valid:
  - word load 2 cycles;
  - word store 2;
  - sub-word store 3;
  - trapped access 1.
- req_ready, mem_we and resp_valid are decoded from the registered state. mem_addr and mem_wdata are registered and stable for the whole RD/WR cycle.
- If resp_ready is held low, the unit stays in DONE indefinitely with outputs stable.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests produce no memory access and return resp_err=1, resp_rdata=0 after one cycle.
- Undefined: resp_err is tied 0. Low address bits are forced to the access size's alignment (halfword clears bit 0, word clears bits 1:0), and the access proceeds normally.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x8, then load word at 0x8 -> mem[2]=0xDEADBEEF; resp_rdata=0xDEADBEEF, 2-cycle latency each.
- Byte store RMW: mem[1]=0x11223344, store byte 0xAA at 0x6 -> exactly one mem_we pulse; mem[1]=0x11AA3344; 3-cycle latency.
- Signed/unsigned load: mem[3]=0x80F0007F. Expected results:
  - lb 0xC -> 0x0000007F;
  - lb 0xF -> 0xFFFFFF80;
  - lhu 0xE -> 0x000080F0;
  - lh 0xE -> 0xFFFF80F0.
- Misaligned word load at 0x5:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1, no mem access, 1-cycle latency;
  - without: reads mem[1], resp_err=0.
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Assert reset during WR -> no mem_we pulse, all outputs 0, req_ready=1 next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into single-word memory accesses,
// with sign/zero-extended loads and read-modify-write sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return resp_err instead of being aligned down.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,      // active low, synchronous
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lo_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              misaligned;
    logic [1:0]        lo_d;
    logic              unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_W+2];

    // Reserved size 2'b11 behaves as a word, so size[1] alone means "word".
    assign misaligned = (req_size_i == 2'b01 && req_addr_i[0]) ||
                        (req_size_i[1] && req_addr_i[1:0] != 2'b00);

    always_comb begin
        lo_d = req_addr_i[1:0];
        if (req_size_i[1])       lo_d = 2'b00;
        else if (req_size_i[0])  lo_d = {req_addr_i[1], 1'b0};
    end

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wd,
                                          input logic [1:0] lo, input logic half);
        logic [31:0] m;
        m = word;
        if (half) begin
            if (lo[1]) m[31:16] = wd;
            else       m[15:0]  = wd;
        end else begin
            case (lo)
                2'd0: m[7:0]   = wd[7:0];
                2'd1: m[15:8]  = wd[7:0];
                2'd2: m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        if (size[1])      return word;
        else if (size[0]) return {{16{sgn & h[15]}}, h};
        else              return {{24{sgn & b[7]}}, b};
    endfunction

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lo_q         <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    write_q      <= req_write_i;
                    size_q       <= req_size_i;
                    signed_q     <= req_signed_i;
                    lo_q         <= lo_d;
                    wdata_q      <= req_wdata_i[15:0];
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    if (TRAP_EN && misaligned) begin
                        resp_err_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        mem_addr_q <= req_addr_i[ADDR_W+1:2];
                        if (req_write_i && req_size_i[1]) begin
                            mem_wdata_q <= req_wdata_i;
                            state_q     <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        mem_wdata_q <= merge(mem_rdata_i, wdata_q, lo_q, size_q[0]);
                        state_q     <= WR;
                    end else begin
                        resp_rdata_q <= extract(mem_rdata_i, lo_q, size_q, signed_q);
                        state_q      <= DONE;
                    end
                end
                WR:      state_q <= DONE;
                default: if (resp_ready_i) state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    // Gated by reset so an aborted write never reaches the memory.
    assign mem_we_o     = (state_q == WR) && reset_i;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized requests, behavioural memory model and a
// scoreboard monitor checking data, error flag, latency and write-pulse count.
module tb_load_store_unit;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic [31:0]       req_addr = '0, req_wdata = '0;
    logic              resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int cyc = 0, we_cnt = 0;
    int n_chk = 0, n_fail = 0;
    bit bp_hold = 1'b0;

    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
        int          we_base;
        int          acc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference semantics: byte-addressed little-endian memory, word index wraps modulo DEPTH.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int s, off, idx;
        logic [31:0] word, sh, mask;
        bit mis;
        s   = (sz == 2'd3) ? 2 : int'(sz);
        mis = (s == 1 && a[0]) || (s == 2 && a[1:0] != 2'b00);
        idx = int'(a[ADDR_W+1:2]);
        e.rdata = '0; e.err = 1'b0; e.we = 0; e.lat = 2; e.we_base = 0; e.acc = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
`else
        if (mis) off = 0;
`endif
        off = int'(a[1:0]);
        if (s == 1) off = off & 2;
        if (s == 2) off = 0;
        if (!w) begin
            word = ref_mem[idx];
            sh   = word >> (8 * off);
            if (s == 0)      e.rdata = (sg && sh[7])  ? (32'hFFFFFF00 | (sh & 32'hFF))   : (sh & 32'hFF);
            else if (s == 1) e.rdata = (sg && sh[15]) ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
            else             e.rdata = word;
        end else begin
            e.we = 1;
            if (s == 2) begin
                ref_mem[idx] = wd;
            end else begin
                mask = ((s == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
                e.lat = 3;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 100) begin @(negedge clk); g++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        e = model(w, sz, sg, a, wd);
        @(posedge clk);
        e.acc = cyc; e.we_base = we_cnt;
        sb.push_back(e);
        // Junk request while busy: must be ignored.
        #1 req_write = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin @(negedge clk); g++; end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2 resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    exp_t        cur;
    bit          seen = 1'b0;
    logic [31:0] h_rd;
    logic        h_err;
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid), 32'd0);
                    cur.rdata = resp_rdata; cur.err = resp_err; cur.lat = 0;
                    cur.acc = cyc; cur.we = 0; cur.we_base = we_cnt;
                end else begin
                    cur = sb.pop_front();
                    chk("latency", cyc - cur.acc, cur.lat);
                end
                h_rd = resp_rdata; h_err = resp_err;
            end else begin
                chk("rdata_stable", resp_rdata, h_rd);
                chk("err_stable", 32'(resp_err), 32'(h_err));
            end
            chk("req_ready_in_done", 32'(req_ready), 32'd0);
            if (resp_ready) begin
                chk("resp_rdata", resp_rdata, cur.rdata);
                chk("resp_err", 32'(resp_err), 32'(cur.err));
                chk("we_pulses", we_cnt - cur.we_base, cur.we);
                seen = 1'b0;
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_err"},   32'(resp_err), 0);
        chk({tag, "_mem_we"},     32'(mem_we), 0);
        chk({tag, "_mem_addr"},   32'(mem_addr), 0);
        chk({tag, "_mem_wdata"},  mem_wdata, 0);
        chk({tag, "_req_ready"},  32'(req_ready), 1);
    endtask

    initial begin
        int base, diffs;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        reset_n = 1'b1;

        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        drain();
        env_mem[1] <= 32'h11223344; ref_mem[1] = 32'h11223344;
        env_mem[3] <= 32'h80F0007F; ref_mem[3] = 32'h80F0007F;
        issue(1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AA);
        issue(1'b0, 2'd0, 1'b1, 32'hC, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'hF, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'hE, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'hE, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h5, 32'h0);
        drain();
        chk("mem2_word_store", env_mem[2], 32'hDEADBEEF);
        chk("mem1_byte_rmw",   env_mem[1], 32'h11AA3344);

        // Backpressure: response must be held while resp_ready stays low.
        bp_hold = 1'b1;
        issue(1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
        repeat (5) @(negedge clk);
        chk("bp_resp_valid", 32'(resp_valid), 1);
        chk("bp_req_ready",  32'(req_ready), 0);
        bp_hold = 1'b0;
        drain();

        // Reset landing on the WR cycle of a word store must suppress the write.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        base = we_cnt;
        #1 req_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        chk_idle_outputs("abort");
        chk("abort_no_write", we_cnt - base, 0);
        reset_n = 1'b1;

        repeat (300)
            issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        drain();

        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (env_mem[i] !== ref_mem[i]) diffs++;
        chk("final_mem_diffs", diffs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
